// File: rtl/nist_health_monitor.sv
// Health aggregator for a bank of online TRNG statistical tests: samples the
// per-test pass flags once per sequence and raises a sticky alarm.
module nist_health_monitor #(
  parameter int NUM_TESTS    = 4,
  parameter int SEQ_LEN      = 2048,
  parameter int SAMPLE_OFS   = 2,
  parameter int WARMUP       = 1,
  parameter int CONSEC_MAX   = 3,
  parameter int WIN          = 16,
  parameter int WIN_FAIL_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_TESTS-1:0] pass_vec,
  input  logic                 clr_alarm,
  output logic                 result_valid,
  output logic                 healthy,
  output logic                 alarm,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [15:0]          seq_count
);

  localparam int CYW = $clog2(SEQ_LEN);
  localparam int CW  = $clog2(CONSEC_MAX + 1);
  localparam int WW  = $clog2(WIN + 1);
  localparam int UW  = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {S_WARMUP, S_MONITOR, S_ALARM} state_t;

  state_t                          state_q, state_d;
  logic [CYW-1:0]                  cyc_q, cyc_d;
  logic                            pend_q, pend_d;
  logic [NUM_TESTS-1:0]            last_q, last_d;
  logic [UW-1:0]                   warm_q, warm_d;
  logic [NUM_TESTS-1:0][CW-1:0]    consec_q, consec_d;
  logic [WW-1:0]                   win_cnt_q, win_cnt_d;
  logic [WW-1:0]                   win_fail_q, win_fail_d;
  logic [NUM_TESTS-1:0]            mask_q, mask_d;
  logic [15:0]                     seq_q, seq_d;
  logic                            rv_q, rv_d;
  logic                            hit;
  logic [NUM_TESTS-1:0]            fails;

  always_comb begin
    state_d    = state_q;
    cyc_d      = (cyc_q == CYW'(SEQ_LEN - 1)) ? '0 : cyc_q + 1'b1;
    pend_d     = 1'b0;
    last_d     = last_q;
    warm_d     = warm_q;
    consec_d   = consec_q;
    win_cnt_d  = win_cnt_q;
    win_fail_d = win_fail_q;
    mask_d     = mask_q;
    seq_d      = seq_q;
    rv_d       = 1'b0;
    hit        = 1'b0;
    fails      = ~last_q;

    if (cyc_q == CYW'(SAMPLE_OFS)) begin
      last_d = pass_vec;
      pend_d = 1'b1;
    end

    if (clr_alarm) begin
      mask_d   = '0;
      consec_d = '0;
      if (state_q == S_ALARM) begin
        win_cnt_d  = '0;
        win_fail_d = '0;
        state_d    = S_MONITOR;
      end
    end

    if (pend_q) begin
      if (state_q == S_WARMUP) begin
        warm_d = warm_q + 1'b1;
        if (warm_d == UW'(WARMUP)) state_d = S_MONITOR;
      end else begin
        // Alarm condition uses the pre-clear history so a coincident clear
        // cannot mask it; the stored counters restart from the cleared base.
        for (int i = 0; i < NUM_TESTS; i++) begin
          if (fails[i]) begin
            if (consec_q[i] >= CW'(CONSEC_MAX - 1)) hit = 1'b1;
            consec_d[i] = (consec_d[i] >= CW'(CONSEC_MAX)) ? CW'(CONSEC_MAX)
                                                           : consec_d[i] + 1'b1;
            mask_d[i]   = 1'b1;
          end else begin
            consec_d[i] = '0;
          end
        end
        if (win_cnt_q == WW'(WIN - 1) &&
            (win_fail_q + WW'(|fails)) >= WW'(WIN_FAIL_MAX)) hit = 1'b1;
        win_cnt_d  = win_cnt_d + 1'b1;
        win_fail_d = win_fail_d + WW'(|fails);
        if (win_cnt_d == WW'(WIN)) begin
          win_cnt_d  = '0;
          win_fail_d = '0;
        end
        seq_d = seq_q + 1'b1;
        rv_d  = 1'b1;
        if (hit) state_d = S_ALARM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WARMUP;
      cyc_q      <= '0;
      pend_q     <= 1'b0;
      last_q     <= '0;
      warm_q     <= '0;
      consec_q   <= '0;
      win_cnt_q  <= '0;
      win_fail_q <= '0;
      mask_q     <= '0;
      seq_q      <= '0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      warm_q     <= warm_d;
      consec_q   <= consec_d;
      win_cnt_q  <= win_cnt_d;
      win_fail_q <= win_fail_d;
      mask_q     <= mask_d;
      seq_q      <= seq_d;
      rv_q       <= rv_d;
    end
  end

  assign result_valid = rv_q;
  assign healthy      = (state_q == S_MONITOR);
  assign alarm        = (state_q == S_ALARM);
  assign fail_mask    = mask_q;
  assign seq_count    = seq_q;

endmodule

// File: tb/tb_nist_health_monitor.sv
// Randomized and directed bench for nist_health_monitor against a per-sample
// behavioural model; a short sequence length keeps the run small.
module tb_nist_health_monitor;
  localparam int NT = 4, SL = 32, SO = 2, WU = 1, CM = 3, W = 16, WFM = 4;
  localparam int CLR_OFS = SO + 6;

  logic clk = 1'b0, rst = 1'b1, clr_alarm = 1'b0;
  logic [NT-1:0] pass_vec = '0;
  logic result_valid, healthy, alarm;
  logic [NT-1:0] fail_mask;
  logic [15:0] seq_count;

  nist_health_monitor #(.NUM_TESTS(NT), .SEQ_LEN(SL), .SAMPLE_OFS(SO), .WARMUP(WU),
    .CONSEC_MAX(CM), .WIN(W), .WIN_FAIL_MAX(WFM)) dut (
    .clk(clk), .rst(rst), .pass_vec(pass_vec), .clr_alarm(clr_alarm),
    .result_valid(result_valid), .healthy(healthy), .alarm(alarm),
    .fail_mask(fail_mask), .seq_count(seq_count));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int abs_cyc;

  // behavioural model state
  bit m_warm_done, m_alarm, exp_rv;
  int m_warm_n, m_wc, m_wf, m_seq;
  int m_consec[NT];
  logic [NT-1:0] m_mask;

  // observations from the last sequence
  int o_rv_cnt, o_rv_at, e_rv_cnt;
  logic o_h, o_a;
  logic [NT-1:0] o_mask;
  logic [15:0] o_seq;

  task automatic model_reset();
    m_warm_done = 0; m_alarm = 0; m_warm_n = 0; m_wc = 0; m_wf = 0; m_seq = 0;
    m_mask = '0;
    for (int i = 0; i < NT; i++) m_consec[i] = 0;
  endtask

  task automatic model_clear();
    m_mask = '0;
    for (int i = 0; i < NT; i++) m_consec[i] = 0;
    if (m_alarm) begin m_wc = 0; m_wf = 0; m_alarm = 0; end
  endtask

  task automatic model_eval(input logic [NT-1:0] pv, input bit clr);
    logic [NT-1:0] f;
    bit hit;
    int nf;
    f = ~pv;
    nf = (f != '0) ? 1 : 0;
    exp_rv = 0;
    if (!m_warm_done) begin
      if (clr) model_clear();
      m_warm_n++;
      if (m_warm_n >= WU) m_warm_done = 1;
      return;
    end
    hit = 0;
    for (int i = 0; i < NT; i++) if (f[i] && m_consec[i] + 1 >= CM) hit = 1;
    if (m_wc + 1 == W && m_wf + nf >= WFM) hit = 1;
    if (clr) model_clear();
    for (int i = 0; i < NT; i++)
      m_consec[i] = f[i] ? ((m_consec[i] + 1 > CM) ? CM : m_consec[i] + 1) : 0;
    m_mask |= f;
    m_wc++;
    m_wf += nf;
    if (m_wc == W) begin m_wc = 0; m_wf = 0; end
    m_seq++;
    exp_rv = 1;
    if (hit) m_alarm = 1;
  endtask

  // Caller sits at the negedge of sequence cycle 0; returns at the next one.
  task automatic seq_step(input logic [NT-1:0] pv, input bit clr_eval, input bit clr_mid);
    o_rv_cnt = 0; o_rv_at = -1; e_rv_cnt = 0;
    for (int c = 0; c < SL; c++) begin
      if (c == SO + 2) begin model_eval(pv, clr_eval); e_rv_cnt = exp_rv ? 1 : 0; end
      if (c == CLR_OFS + 1 && clr_mid) model_clear();
      if (result_valid) begin o_rv_cnt++; o_rv_at = abs_cyc; end
      if (c == SL - 1) begin
        o_h = healthy; o_a = alarm; o_mask = fail_mask; o_seq = seq_count;
      end
      pass_vec  = (c == SO) ? pv : NT'($urandom);
      clr_alarm = (c == SO + 1 && clr_eval) || (c == CLR_OFS && clr_mid);
      abs_cyc++;
      @(negedge clk);
    end
    clr_alarm = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clr_alarm = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    abs_cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      pass_vec = NT'($urandom);
      @(negedge clk);
    end
    n_tests++;
    if ({result_valid, healthy, alarm, fail_mask, seq_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b h=%b a=%b mask=%b seq=%0d want all 0",
               result_valid, healthy, alarm, fail_mask, seq_count);
    end
  endtask

  task automatic test_warmup();
    do_reset();
    seq_step(4'hF, 0, 0);
    n_tests++;
    if (o_rv_cnt !== 0) begin
      n_fail++; $display("FAIL warmup_no_rv: got %0d pulses want 0", o_rv_cnt);
    end
    seq_step(4'hF, 0, 0);
    n_tests++;
    if (o_rv_at !== WU * SL + SO + 2 || o_rv_cnt !== 1) begin
      n_fail++;
      $display("FAIL first_rv_cycle: got cycle %0d (%0d pulses) want cycle %0d (1 pulse)",
               o_rv_at, o_rv_cnt, WU * SL + SO + 2);
    end
    seq_step(4'hF, 0, 0);
    n_tests++;
    if (o_h !== 1'b1 || o_a !== 1'b0 || o_seq !== 16'd2 || o_mask !== 4'h0) begin
      n_fail++;
      $display("FAIL steady_healthy: got h=%b a=%b seq=%0d mask=%b want h=1 a=0 seq=2 mask=0000",
               o_h, o_a, o_seq, o_mask);
    end
  endtask

  task automatic test_consec();
    do_reset();
    seq_step(4'hF, 0, 0);
    seq_step(4'hB, 0, 0);
    seq_step(4'hB, 0, 0);
    n_tests++;
    if (o_a !== 1'b0 || o_h !== 1'b1) begin
      n_fail++; $display("FAIL consec_two: got a=%b h=%b want a=0 h=1", o_a, o_h);
    end
    seq_step(4'hB, 0, 0);
    n_tests++;
    if (o_a !== 1'b1 || o_h !== 1'b0 || o_mask !== 4'b0100) begin
      n_fail++;
      $display("FAIL consec_alarm: got a=%b h=%b mask=%b want a=1 h=0 mask=0100",
               o_a, o_h, o_mask);
    end
  endtask

  task automatic test_window();
    do_reset();
    seq_step(4'hF, 0, 0);
    for (int s = 0; s < W; s++) begin
      seq_step((s % 2 == 0) ? 4'hE : 4'hF, 0, 0);
      if (s >= W - 2) begin
        n_tests++;
        if (o_a !== ((s == W - 1) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL window_8of16 sample %0d: got a=%b want %b", s + 1, o_a, s == W - 1);
        end
      end
    end
    do_reset();
    seq_step(4'hF, 0, 0);
    for (int s = 0; s < 2 * W; s++) seq_step((s % W) % 5 == 0 && (s % W) < 15 ? 4'hE : 4'hF, 0, 0);
    n_tests++;
    if (o_a !== 1'b0 || o_a !== m_alarm || o_seq !== 16'(2 * W)) begin
      n_fail++;
      $display("FAIL window_3of16_twice: got a=%b seq=%0d want a=0 seq=%0d", o_a, o_seq, 2 * W);
    end
  endtask

  task automatic test_clear();
    do_reset();
    seq_step(4'hF, 0, 0);
    repeat (3) seq_step(4'hB, 0, 0);
    seq_step(4'hF, 0, 1);
    n_tests++;
    if (o_a !== 1'b0 || o_h !== 1'b1 || o_mask !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_alarm: got a=%b h=%b mask=%b want a=0 h=1 mask=0000", o_a, o_h, o_mask);
    end
    repeat (2) seq_step(4'hB, 0, 0);
    n_tests++;
    if (o_a !== 1'b0) begin
      n_fail++; $display("FAIL clear_consec_restart: got a=%b want 0", o_a);
    end
    seq_step(4'hB, 0, 0);
    n_tests++;
    if (o_a !== 1'b1 || o_mask !== 4'b0100) begin
      n_fail++; $display("FAIL clear_realarm: got a=%b mask=%b want a=1 mask=0100", o_a, o_mask);
    end
  endtask

  task automatic test_clr_set_wins();
    do_reset();
    seq_step(4'hF, 0, 0);
    seq_step(4'h7, 0, 0);
    seq_step(4'hE, 0, 0);
    seq_step(4'hE, 0, 0);
    seq_step(4'hE, 1, 0);
    n_tests++;
    if (o_a !== 1'b1 || o_mask !== 4'b0001 || o_rv_cnt !== 1) begin
      n_fail++;
      $display("FAIL clr_set_wins: got a=%b mask=%b rv=%0d want a=1 mask=0001 rv=1",
               o_a, o_mask, o_rv_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    seq_step(4'hF, 0, 0);
    seq_step(4'hD, 0, 0);
    seq_step(4'hD, 0, 0);
    repeat (7) @(negedge clk);
    rst = 1'b1; pass_vec = 4'hD;
    @(negedge clk);
    n_tests++;
    if ({result_valid, healthy, alarm, fail_mask, seq_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rv=%b h=%b a=%b mask=%b seq=%0d want all 0",
               result_valid, healthy, alarm, fail_mask, seq_count);
    end
    do_reset();
    seq_step(4'hD, 0, 0);
    seq_step(4'hD, 0, 0);
    n_tests++;
    if (o_a !== 1'b0 || o_h !== 1'b1 || o_mask !== 4'b0010 || o_seq !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got a=%b h=%b mask=%b seq=%0d want a=0 h=1 mask=0010 seq=1",
               o_a, o_h, o_mask, o_seq);
    end
  endtask

  task automatic test_random();
    logic [NT-1:0] pv;
    do_reset();
    for (int s = 0; s < 80; s++) begin
      for (int i = 0; i < NT; i++) pv[i] = ($urandom_range(0, 5) != 0);
      seq_step(pv, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      n_tests++;
      if (o_a !== m_alarm || o_h !== (m_warm_done && !m_alarm) || o_mask !== m_mask ||
          o_seq !== 16'(m_seq) || o_rv_cnt !== e_rv_cnt) begin
        n_fail++;
        $display("FAIL random seq %0d: got a=%b h=%b mask=%b seq=%0d rv=%0d want a=%b h=%b mask=%b seq=%0d rv=%0d",
                 s, o_a, o_h, o_mask, o_seq, o_rv_cnt, m_alarm, m_warm_done && !m_alarm,
                 m_mask, m_seq, e_rv_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_consec();
    test_window();
    test_clear();
    test_clr_set_wins();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
